reg_file_sb: RTL and testbench
==============================

# reg_file_sb

Register file with an integrated write-back scoreboard. It is the consumer of the WB stage's outputs: it takes write data, RegWrite and the destination register, commits them, and bypasses them to the same-cycle ID-stage reads. It also tracks in-flight destination registers issued by ID. This lets the hazard logic stall on operands that WB has not yet written.

## Interface
- DATA_W, 32, register and data width
- ADDR_W, 5, register index width (2**ADDR_W registers)
- CNT_W, 2, per-register in-flight counter width; saturates at 2**CNT_W-1 = 3
- Clk  input  1  clock; all state updates on posedge
- Rst_n  input  1  reset, synchronous, active-low
- In_RegWrite  input  1  write enable from WB (WBControl[0] after WB)
- In_WriteReg  input  ADDR_W  destination register from WB
- In_WriteData  input  DATA_W  write data from WB (Out_Data of WB)
- In_ReadRegA  input  ADDR_W  ID rs index
- In_ReadRegB  input  ADDR_W  ID rt index
- Out_ReadDataA  output  DATA_W  rs value
- Out_ReadDataB  output  DATA_W  rt value
- In_IssueValid  input  1  ID issues an instruction that writes In_IssueReg
- In_IssueReg  input  ADDR_W  destination register of the issued instruction
- Out_PendingA  output  1  rs has an outstanding write not satisfied this cycle
- Out_PendingB  output  1  rt likewise
- Out_IssueStall  output  1  issue refused: counter for In_IssueReg saturated
- Out_SbError  output  1  sticky: a write-back arrived for a register with count 0

## Operation
- Write is effective when In_RegWrite=1 and In_WriteReg≠0. On the posedge, reg[In_WriteReg] ← In_WriteData.
- Register 0 always reads 0. Writes to register 0 are discarded and do not touch the scoreboard.
- Reads are combinational. If an effective write targets the read index in the same cycle, the output is In_WriteData (bypass). Otherwise the output is the array value.
- The scoreboard keeps one count[r] per register r≠0, in the range 0..3.
  - Issue is effective when In_IssueValid=1, In_IssueReg≠0 and Out_IssueStall=0.
  - A decrement occurs on an effective write with count[In_WriteReg]>0.
  - Issue and decrement in the same cycle on the same register leave the count unchanged.
  - An effective write with count[In_WriteReg]=0 sets Out_SbError. The data is still written and the count stays 0.
- Out_PendingA = count[In_ReadRegA]≥1, except that it is 0 when:
  - count[In_ReadRegA]=1 and an effective write to In_ReadRegA occurs this cycle (the bypass satisfies it), or
  - In_ReadRegA=0.
  - Out_PendingB is defined the same way for In_ReadRegB.
- Out_IssueStall = In_IssueValid and count[In_IssueReg]=3 and no effective write to In_IssueReg this cycle. A stalled issue does not change any count.
- Reset (Rst_n=0 at a posedge):
  - all registers ← 0, all counts ← 0, Out_SbError ← 0;
  - a write or issue presented in that cycle is dropped.

## Timing
- Write latency: 0 cycles through the bypass, 1 cycle through the array (visible after the posedge).
- Pending, stall and read outputs are combinational from current inputs and registered state. No extra pipeline stage.
- Output values after reset: Out_ReadDataA/B = 0 for any index, unless bypassed. Out_PendingA/B = 0. Out_IssueStall = 0, or 1 only if the issue is valid to a saturated register, which is impossible right after reset. Out_SbError = 0.
- Count changes take effect on the posedge after issue or write-back. Pending reflects the new count from the next cycle.
- Out_SbError stays set until reset.

## Structure
- Shared package `pipe_pkg`:
  - DATA_W, ADDR_W, REG_ZERO = 0;
  - WBControl bit indices WB_MEMTOREG = 1 and WB_REGWRITE = 0, shared with WB, MEM and ID.
- Sub-module `reg_scoreboard`:
  - holds the count array and the issue/write-back update rules, including saturation and error;
  - produces pending/stall/error.
- `reg_file_sb` holds the data array, the bypass muxes and register-0 handling, and instantiates `reg_scoreboard`.

## Test plan
- Reset, then read A=5, B=0 → Out_ReadDataA=0, Out_ReadDataB=0, Out_PendingA=Out_PendingB=0.
- Write reg 3=0xDEADBEEF while reading A=3 in the same cycle → Out_ReadDataA=0xDEADBEEF (bypass). Next cycle with no write → array returns 0xDEADBEEF.
- Write reg 0=0x12345678, then read A=0 → 0. Out_SbError stays 0.
- Issue reg 7 four times in consecutive cycles → the fourth cycle shows Out_IssueStall=1 and count stays 3. Then write-back reg 7 in the same cycle as issue reg 7 → no stall, count stays 3.
- Issue reg 9 once; next cycle read A=9 → Out_PendingA=1. Write-back reg 9 with A=9 in that same cycle → Out_PendingA=0 and data bypassed. Next cycle → count 0, pending 0.
- Write-back reg 4 with count 0 → Out_SbError=1 and reg 4 updated. Assert Rst_n=0 during a write to reg 4 → after reset reg 4 reads 0, Out_SbError=0, all pending 0.

Source files
------------

// File: rtl/pipe_pkg.sv
// Pipeline-wide widths and control-bit positions shared by the ID, MEM and WB stages
// and the register file.
package pipe_pkg;

    localparam int unsigned DATA_W   = 32;
    localparam int unsigned ADDR_W   = 5;
    localparam int unsigned CNT_W    = 2;
    localparam int unsigned REG_ZERO = 0;

    // Bit positions within WBControl
    localparam int unsigned WB_MEMTOREG = 1;
    localparam int unsigned WB_REGWRITE = 0;

endpackage

// File: rtl/reg_scoreboard.sv
// Per-register in-flight write counters: ID issue increments, WB write-back decrements.
// Produces operand-pending, issue-stall and a sticky underflow error.
module reg_scoreboard #(
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned CNT_W  = 2
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              wr_en_i,      // effective write: already excludes register 0
    input  logic [ADDR_W-1:0] wr_reg_i,
    input  logic              issue_valid_i,
    input  logic [ADDR_W-1:0] issue_reg_i,
    input  logic [ADDR_W-1:0] rd_a_i,
    input  logic [ADDR_W-1:0] rd_b_i,
    output logic              pending_a_o,
    output logic              pending_b_o,
    output logic              issue_stall_o,
    output logic              sb_error_o
);
    import pipe_pkg::*;

    localparam int unsigned       NumRegs = 2 ** ADDR_W;
    localparam logic [CNT_W-1:0]  CntMax  = '1;
    localparam logic [CNT_W-1:0]  CntOne  = CNT_W'(1);
    localparam logic [ADDR_W-1:0] RegZero = ADDR_W'(REG_ZERO);

    logic [CNT_W-1:0] count_q [NumRegs];
    logic [CNT_W-1:0] count_d [NumRegs];
    logic             sb_error_q, sb_error_d;
    logic             issue_eff;

    // A write-back to the saturated register frees a slot in the same cycle.
    assign issue_stall_o = issue_valid_i && (count_q[issue_reg_i] == CntMax) &&
                           !(wr_en_i && (wr_reg_i == issue_reg_i));
    assign issue_eff     = issue_valid_i && (issue_reg_i != RegZero) && !issue_stall_o;

    always_comb begin
        sb_error_d = sb_error_q || (wr_en_i && (count_q[wr_reg_i] == '0));
        for (int unsigned r = 0; r < NumRegs; r++) begin
            logic inc, dec;
            count_d[r] = count_q[r];
            inc = issue_eff && (issue_reg_i == ADDR_W'(r));
            dec = wr_en_i && (wr_reg_i == ADDR_W'(r)) && (count_q[r] != '0);
            if (inc && !dec) begin
                count_d[r] = count_q[r] + CntOne;
            end else if (dec && !inc) begin
                count_d[r] = count_q[r] - CntOne;
            end
        end
        count_d[0] = '0;
    end

    always_comb begin
        pending_a_o = (rd_a_i != RegZero) && (count_q[rd_a_i] != '0) &&
                      !((count_q[rd_a_i] == CntOne) && wr_en_i && (wr_reg_i == rd_a_i));
        pending_b_o = (rd_b_i != RegZero) && (count_q[rd_b_i] != '0) &&
                      !((count_q[rd_b_i] == CntOne) && wr_en_i && (wr_reg_i == rd_b_i));
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int unsigned r = 0; r < NumRegs; r++) begin
                count_q[r] <= '0;
            end
            sb_error_q <= 1'b0;
        end else begin
            for (int unsigned r = 0; r < NumRegs; r++) begin
                count_q[r] <= count_d[r];
            end
            sb_error_q <= sb_error_d;
        end
    end

    assign sb_error_o = sb_error_q;

endmodule

// File: rtl/reg_file_sb.sv
// Register file with same-cycle WB-to-ID bypass and an integrated write-back scoreboard.
// Register 0 reads as zero and ignores writes.
module reg_file_sb #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned CNT_W  = 2
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              In_RegWrite,
    input  logic [ADDR_W-1:0] In_WriteReg,
    input  logic [DATA_W-1:0] In_WriteData,
    input  logic [ADDR_W-1:0] In_ReadRegA,
    input  logic [ADDR_W-1:0] In_ReadRegB,
    output logic [DATA_W-1:0] Out_ReadDataA,
    output logic [DATA_W-1:0] Out_ReadDataB,
    input  logic              In_IssueValid,
    input  logic [ADDR_W-1:0] In_IssueReg,
    output logic              Out_PendingA,
    output logic              Out_PendingB,
    output logic              Out_IssueStall,
    output logic              Out_SbError
);
    import pipe_pkg::*;

    localparam int unsigned       NumRegs = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] RegZero = ADDR_W'(REG_ZERO);

    logic [DATA_W-1:0] regs_q [NumRegs];
    logic              wr_en;

    assign wr_en = In_RegWrite && (In_WriteReg != RegZero);

    always_comb begin
        if (In_ReadRegA == RegZero) begin
            Out_ReadDataA = '0;
        end else if (wr_en && (In_WriteReg == In_ReadRegA)) begin
            Out_ReadDataA = In_WriteData;
        end else begin
            Out_ReadDataA = regs_q[In_ReadRegA];
        end

        if (In_ReadRegB == RegZero) begin
            Out_ReadDataB = '0;
        end else if (wr_en && (In_WriteReg == In_ReadRegB)) begin
            Out_ReadDataB = In_WriteData;
        end else begin
            Out_ReadDataB = regs_q[In_ReadRegB];
        end
    end

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            for (int unsigned r = 0; r < NumRegs; r++) begin
                regs_q[r] <= '0;
            end
        end else if (wr_en) begin
            regs_q[In_WriteReg] <= In_WriteData;
        end
    end

    reg_scoreboard #(
        .ADDR_W (ADDR_W),
        .CNT_W  (CNT_W)
    ) u_scoreboard (
        .clk_i         (Clk),
        .rst_ni        (Rst_n),
        .wr_en_i       (wr_en),
        .wr_reg_i      (In_WriteReg),
        .issue_valid_i (In_IssueValid),
        .issue_reg_i   (In_IssueReg),
        .rd_a_i        (In_ReadRegA),
        .rd_b_i        (In_ReadRegB),
        .pending_a_o   (Out_PendingA),
        .pending_b_o   (Out_PendingB),
        .issue_stall_o (Out_IssueStall),
        .sb_error_o    (Out_SbError)
    );

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed bench for reg_file_sb: a per-cycle vector table plus a hand-written
// pending/drain sequence.
module tb_reg_file_sb;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 5;

    logic          Clk = 1'b0;
    logic          Rst_n;
    logic          In_RegWrite;
    logic [AW-1:0] In_WriteReg;
    logic [DW-1:0] In_WriteData;
    logic [AW-1:0] In_ReadRegA;
    logic [AW-1:0] In_ReadRegB;
    logic [DW-1:0] Out_ReadDataA;
    logic [DW-1:0] Out_ReadDataB;
    logic          In_IssueValid;
    logic [AW-1:0] In_IssueReg;
    logic          Out_PendingA;
    logic          Out_PendingB;
    logic          Out_IssueStall;
    logic          Out_SbError;

    int checks = 0;
    int errors = 0;

    always #5 Clk = ~Clk;

    reg_file_sb dut (
        .Clk            (Clk),
        .Rst_n          (Rst_n),
        .In_RegWrite    (In_RegWrite),
        .In_WriteReg    (In_WriteReg),
        .In_WriteData   (In_WriteData),
        .In_ReadRegA    (In_ReadRegA),
        .In_ReadRegB    (In_ReadRegB),
        .Out_ReadDataA  (Out_ReadDataA),
        .Out_ReadDataB  (Out_ReadDataB),
        .In_IssueValid  (In_IssueValid),
        .In_IssueReg    (In_IssueReg),
        .Out_PendingA   (Out_PendingA),
        .Out_PendingB   (Out_PendingB),
        .Out_IssueStall (Out_IssueStall),
        .Out_SbError    (Out_SbError)
    );

    typedef struct {
        logic          rst_n;
        logic          we;
        logic [AW-1:0] wreg;
        logic [DW-1:0] wdata;
        logic [AW-1:0] ra;
        logic [AW-1:0] rb;
        logic          iv;
        logic [AW-1:0] ireg;
        logic [DW-1:0] exp_a;
        logic [DW-1:0] exp_b;
        logic          exp_pa;
        logic          exp_pb;
        logic          exp_stall;
        logic          exp_err;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic rst_n, input logic we, input int wreg, input logic [DW-1:0] wdata,
                       input int ra, input int rb, input logic iv, input int ireg,
                       input logic [DW-1:0] ea, input logic [DW-1:0] eb, input logic pa,
                       input logic pb, input logic st, input logic er);
        vec_t v;
        v.rst_n = rst_n; v.we = we; v.wreg = AW'(wreg); v.wdata = wdata;
        v.ra = AW'(ra); v.rb = AW'(rb); v.iv = iv; v.ireg = AW'(ireg);
        v.exp_a = ea; v.exp_b = eb; v.exp_pa = pa; v.exp_pb = pb;
        v.exp_stall = st; v.exp_err = er;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rst_n, input logic we, input int wreg, input logic [DW-1:0] wdata,
                         input int ra, input int rb, input logic iv, input int ireg);
        @(negedge Clk);
        Rst_n = rst_n; In_RegWrite = we; In_WriteReg = AW'(wreg); In_WriteData = wdata;
        In_ReadRegA = AW'(ra); In_ReadRegB = AW'(rb); In_IssueValid = iv; In_IssueReg = AW'(ireg);
        #1;
    endtask

    initial begin
        Rst_n = 1'b0; In_RegWrite = 1'b0; In_WriteReg = '0; In_WriteData = '0;
        In_ReadRegA = '0; In_ReadRegB = '0; In_IssueValid = 1'b0; In_IssueReg = '0;
        repeat (2) @(posedge Clk);

        //   rst we wreg wdata         ra rb iv ireg  exp_a          exp_b          pa pb st er
        add(1, 0, 0, 32'h0,          5, 0, 0, 0,   32'h0,          32'h0,          0, 0, 0, 0);
        add(1, 0, 0, 32'h0,          3, 3, 1, 3,   32'h0,          32'h0,          0, 0, 0, 0);
        add(1, 1, 3, 32'hDEADBEEF,   3, 3, 0, 0,   32'hDEADBEEF,   32'hDEADBEEF,   0, 0, 0, 0);
        add(1, 0, 0, 32'h0,          3, 0, 0, 0,   32'hDEADBEEF,   32'h0,          0, 0, 0, 0);
        add(1, 1, 0, 32'h12345678,   0, 3, 0, 0,   32'h0,          32'hDEADBEEF,   0, 0, 0, 0);
        add(1, 0, 0, 32'h0,          0, 0, 0, 0,   32'h0,          32'h0,          0, 0, 0, 0);
        add(1, 0, 0, 32'h0,          7, 0, 1, 7,   32'h0,          32'h0,          0, 0, 0, 0);
        add(1, 0, 0, 32'h0,          7, 0, 1, 7,   32'h0,          32'h0,          1, 0, 0, 0);
        add(1, 0, 0, 32'h0,          7, 0, 1, 7,   32'h0,          32'h0,          1, 0, 0, 0);
        add(1, 0, 0, 32'h0,          7, 0, 1, 7,   32'h0,          32'h0,          1, 0, 1, 0);
        add(1, 0, 0, 32'h0,          7, 0, 1, 7,   32'h0,          32'h0,          1, 0, 1, 0);
        add(1, 1, 7, 32'h77,         7, 0, 1, 7,   32'h77,         32'h0,          1, 0, 0, 0);
        add(1, 0, 0, 32'h0,          0, 7, 1, 7,   32'h0,          32'h77,         0, 1, 1, 0);
        add(1, 0, 0, 32'h0,          9, 0, 1, 9,   32'h0,          32'h0,          0, 0, 0, 0);
        add(1, 0, 0, 32'h0,          9, 7, 0, 0,   32'h0,          32'h77,         1, 1, 0, 0);
        add(1, 1, 9, 32'h99,         9, 7, 0, 0,   32'h99,         32'h77,         0, 1, 0, 0);
        add(1, 0, 0, 32'h0,          9, 0, 0, 0,   32'h99,         32'h0,          0, 0, 0, 0);
        add(1, 0, 0, 32'h0,          0, 0, 1, 0,   32'h0,          32'h0,          0, 0, 0, 0);
        add(1, 1, 4, 32'hA5A5A5A5,   4, 0, 0, 0,   32'hA5A5A5A5,   32'h0,          0, 0, 0, 0);
        add(1, 0, 0, 32'h0,          4, 0, 0, 0,   32'hA5A5A5A5,   32'h0,          0, 0, 0, 1);
        add(0, 1, 4, 32'h11111111,   4, 7, 1, 9,   32'h11111111,   32'h77,         0, 1, 0, 1);
        add(1, 0, 0, 32'h0,          4, 7, 0, 0,   32'h0,          32'h0,          0, 0, 0, 0);
        add(1, 0, 0, 32'h0,          9, 3, 0, 0,   32'h0,          32'h0,          0, 0, 0, 0);

        foreach (vecs[i]) begin
            drive(vecs[i].rst_n, vecs[i].we, int'(vecs[i].wreg), vecs[i].wdata,
                  int'(vecs[i].ra), int'(vecs[i].rb), vecs[i].iv, int'(vecs[i].ireg));
            check($sformatf("v%0d read_a", i), Out_ReadDataA, vecs[i].exp_a);
            check($sformatf("v%0d read_b", i), Out_ReadDataB, vecs[i].exp_b);
            check($sformatf("v%0d pending_a", i), 32'(Out_PendingA), 32'(vecs[i].exp_pa));
            check($sformatf("v%0d pending_b", i), 32'(Out_PendingB), 32'(vecs[i].exp_pb));
            check($sformatf("v%0d issue_stall", i), 32'(Out_IssueStall), 32'(vecs[i].exp_stall));
            check($sformatf("v%0d sb_error", i), 32'(Out_SbError), 32'(vecs[i].exp_err));
        end

        // Two issues to reg 5, then drain: pending holds until the last write-back.
        drive(1, 0, 0, 32'h0, 5, 0, 1, 5);
        drive(1, 0, 0, 32'h0, 5, 0, 1, 5);
        check("seq pend_after_1", 32'(Out_PendingA), 32'd1);
        drive(1, 1, 5, 32'h55, 5, 0, 0, 0);
        check("seq pend_cnt2_wb", 32'(Out_PendingA), 32'd1);
        check("seq bypass_5", Out_ReadDataA, 32'h55);
        drive(1, 1, 5, 32'h56, 0, 5, 0, 0);
        check("seq pend_cnt1_wb", 32'(Out_PendingB), 32'd0);
        drive(1, 0, 0, 32'h0, 5, 5, 0, 0);
        check("seq pend_drained", 32'(Out_PendingA), 32'd0);
        check("seq array_5", Out_ReadDataB, 32'h56);
        check("seq no_error", 32'(Out_SbError), 32'd0);
        // Issue and write-back together on a count-1 register keeps it pending.
        drive(1, 0, 0, 32'h0, 0, 0, 1, 6);
        drive(1, 1, 6, 32'h66, 6, 0, 1, 6);
        check("seq same_cycle_pend", 32'(Out_PendingA), 32'd0);
        drive(1, 0, 0, 32'h0, 6, 0, 0, 0);
        check("seq count_held", 32'(Out_PendingA), 32'd1);
        check("seq no_error2", 32'(Out_SbError), 32'd0);

        @(negedge Clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
